button_debouncer: RTL

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_debouncer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/button_debouncer.sv
// Push-button debouncer: two-flop synchronizer feeding a four-state
// qualification FSM. A level change is accepted only after DEBOUNCE_CYCLES
// consecutive agreeing synchronized samples; accepted changes update the
// registered level and raise a one-cycle strobe.
// Optional feature macro: BUTTON_DEBOUNCER_FALL_PULSE_EN adds the fallPulse
// strobe port and logic. When it is undefined, high-to-low acceptance still
// updates level but raises no strobe.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic rawIn,
    output logic level,
    output logic risePulse,
`ifdef BUTTON_DEBOUNCER_FALL_PULSE_EN
    output logic fallPulse,
`endif
    output logic busy
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1. It is kept at least
    // one bit wide so that the minimum legal setting still synthesizes.
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE_LOW    = 2'd0,
        CHECK_HIGH  = 2'd1,
        STABLE_HIGH = 2'd2,
        CHECK_LOW   = 2'd3
    } state_e;

    logic       sync1_q;
    logic       sync2_q;
    state_e     state_q;
    state_e     state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic       level_q;
    logic       level_d;
    logic       rise_q;
    logic       rise_d;
`ifdef BUTTON_DEBOUNCER_FALL_PULSE_EN
    logic       fall_q;
    logic       fall_d;
`endif

    // Two-flop synchronizer bringing the asynchronous button level into the clock domain.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= rawIn;
            sync2_q <= sync1_q;
        end
    end

    // Next-state, counter and strobe decode; strobes default low so they last exactly one cycle.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        level_d = level_q;
        rise_d  = 1'b0;
`ifdef BUTTON_DEBOUNCER_FALL_PULSE_EN
        fall_d  = 1'b0;
`endif
        case (state_q)
            IDLE_LOW: begin
                if (sync2_q) begin
                    state_d = CHECK_HIGH;
                    count_d = CNT_ONE;
                end else begin
                    count_d = CNT_ZERO;
                end
            end
            CHECK_HIGH: begin
                if (!sync2_q) begin
                    // Bounce: fall back to the previous stable state silently.
                    state_d = IDLE_LOW;
                    count_d = CNT_ZERO;
                end else if (count_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                    count_d = CNT_ZERO;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!sync2_q) begin
                    state_d = CHECK_LOW;
                    count_d = CNT_ONE;
                end else begin
                    count_d = CNT_ZERO;
                end
            end
            CHECK_LOW: begin
                if (sync2_q) begin
                    state_d = STABLE_HIGH;
                    count_d = CNT_ZERO;
                end else if (count_q == CNT_LAST) begin
                    state_d = IDLE_LOW;
                    count_d = CNT_ZERO;
                    level_d = 1'b0;
`ifdef BUTTON_DEBOUNCER_FALL_PULSE_EN
                    fall_d  = 1'b1;
`endif
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                count_d = CNT_ZERO;
                level_d = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs; reset wins over any qualification or strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE_LOW;
            count_q <= CNT_ZERO;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
`ifdef BUTTON_DEBOUNCER_FALL_PULSE_EN
            fall_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            level_q <= level_d;
            rise_q  <= rise_d;
`ifdef BUTTON_DEBOUNCER_FALL_PULSE_EN
            fall_q  <= fall_d;
`endif
        end
    end

    assign level     = level_q;
    assign risePulse = rise_q;
`ifdef BUTTON_DEBOUNCER_FALL_PULSE_EN
    assign fallPulse = fall_q;
`endif
    // busy is a pure decode of the state register.
    assign busy = (state_q == CHECK_HIGH) || (state_q == CHECK_LOW);

endmodule
